// File: rtl/gcd_lcm_if.sv
// Handshake and data bundle between a requester and the GCD/LCM engine.
interface gcd_lcm_if #(
    parameter int WIDTH = 8
) ();
    logic                 start;
    logic                 mode;
    logic [WIDTH-1:0]     in1;
    logic [WIDTH-1:0]     in2;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 err;

    modport master (
        output start, mode, in1, in2,
        input  busy, done, result, err
    );

    modport slave (
        input  start, mode, in1, in2,
        output busy, done, result, err
    );
endinterface

// File: rtl/gcd_lcm_engine.sv
// Multi-cycle GCD / LCM engine.
// GCD uses repeated subtraction. LCM divides a0 by the GCD (restoring
// division) and then multiplies the quotient by b0 (shift-add).
module gcd_lcm_engine #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    gcd_lcm_if.slave   bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, CALC, DIV, MUL, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     a, b, a0, b0, rem;
    logic                 m;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc, result_q;
    logic                 err_q;

    // a doubles as the dividend/quotient shift register in DIV and as the
    // multiplier shift register in MUL; b holds the GCD (the divisor).
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH-1:0]     rem_diff;
    logic                 quo_bit;
    logic [2*WIDTH-1:0]   addend, mul_sum;

    assign rem_shift = {rem, a[WIDTH-1]};
    assign quo_bit   = (rem_shift >= {1'b0, b});
    // Only used when quo_bit is set, so the true difference is below b.
    assign rem_diff  = rem_shift[WIDTH-1:0] - b;
    assign addend    = a[0] ? ({{WIDTH{1'b0}}, b0} << cnt) : '0;
    assign mul_sum   = acc + addend;

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign bus.err    = err_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = CALC;
            CALC: begin
                if (a == '0 || b == '0) state_nxt = DONE;
                else if (a == b)        state_nxt = m ? DIV : DONE;
            end
            DIV:  if (cnt == LAST) state_nxt = MUL;
            MUL:  if (cnt == LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, subtraction, division, multiplication.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every datapath register is cleared because reset must
            // leave outputs and internal state at a known zero.
            a        <= '0;
            b        <= '0;
            a0       <= '0;
            b0       <= '0;
            rem      <= '0;
            m        <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a  <= bus.in1;
                        b  <= bus.in2;
                        a0 <= bus.in1;
                        b0 <= bus.in2;
                        m  <= bus.mode;
                    end
                end
                CALC: begin
                    if (a == '0 || b == '0) begin
                        result_q <= m ? '0 : {{WIDTH{1'b0}}, a | b};
                        err_q    <= (a == '0) && (b == '0);
                    end else if (a == b) begin
                        if (!m) begin
                            result_q <= {{WIDTH{1'b0}}, a};
                            err_q    <= 1'b0;
                        end else begin
                            a   <= a0;
                            rem <= '0;
                            cnt <= '0;
                            acc <= '0;
                        end
                    end else if (a > b) begin
                        a <= a - b;
                    end else begin
                        b <= b - a;
                    end
                end
                DIV: begin
                    rem <= quo_bit ? rem_diff : rem_shift[WIDTH-1:0];
                    a   <= {a[WIDTH-2:0], quo_bit};
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                MUL: begin
                    acc <= mul_sum;
                    a   <= a >> 1;
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    if (cnt == LAST) begin
                        result_q <= mul_sum;
                        err_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_lcm_engine.sv
// Directed bench for gcd_lcm_engine at WIDTH = 4, 8 and 16.
module tb_gcd_lcm_engine;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gcd_lcm_if #(.WIDTH(4))  if4 ();
    gcd_lcm_if #(.WIDTH(8))  if8 ();
    gcd_lcm_if #(.WIDTH(16)) if16 ();

    gcd_lcm_engine #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(if4));
    gcd_lcm_engine #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));
    gcd_lcm_engine #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));

    typedef struct {
        int          w;
        logic        mode;
        logic [15:0] in1;
        logic [15:0] in2;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic md,
                         input logic [15:0] x, input logic [15:0] y);
        case (w)
            4: begin if4.start = s; if4.mode = md; if4.in1 = x[3:0]; if4.in2 = y[3:0]; end
            8: begin if8.start = s; if8.mode = md; if8.in1 = x[7:0]; if8.in2 = y[7:0]; end
            default: begin if16.start = s; if16.mode = md; if16.in1 = x; if16.in2 = y; end
        endcase
    endtask

    function automatic logic get_busy(input int w);
        case (w)
            4:       return if4.busy;
            8:       return if8.busy;
            default: return if16.busy;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            4:       return if4.done;
            8:       return if8.done;
            default: return if16.done;
        endcase
    endfunction

    function automatic logic get_err(input int w);
        case (w)
            4:       return if4.err;
            8:       return if8.err;
            default: return if16.err;
        endcase
    endfunction

    function automatic logic [31:0] get_result(input int w);
        case (w)
            4:       return 32'(if4.result);
            8:       return 32'(if8.result);
            default: return 32'(if16.result);
        endcase
    endfunction

    // Wait for done, counting edges from 'lat_in'; bounded.
    task automatic wait_done(input int w, input int lat_in, output int lat,
                             output logic seen, output logic busy_ok);
        lat     = lat_in;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
            if (get_done(w)) seen = 1'b1;
            else if (!get_busy(w)) busy_ok = 1'b0;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   lat;
        logic seen, busy_ok;
        @(negedge clk);
        drive(v.w, 1'b1, v.mode, v.in1, v.in2);
        @(posedge clk); #1;
        drive(v.w, 1'b0, v.mode, v.in1, v.in2);
        check($sformatf("v%0d_busy_after_capture", idx), 32'(get_busy(v.w)), 32'd1);
        wait_done(v.w, 0, lat, seen, busy_ok);
        check($sformatf("v%0d_done_seen", idx), 32'(seen), 32'd1);
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d_result", idx), get_result(v.w), v.res);
        check($sformatf("v%0d_err", idx), 32'(get_err(v.w)), 32'(v.err));
        check($sformatf("v%0d_busy_held", idx), 32'(busy_ok), 32'd1);
        @(posedge clk); #1;
        check($sformatf("v%0d_done_one_cycle", idx), 32'(get_done(v.w)), 32'd0);
        check($sformatf("v%0d_idle_after", idx), 32'(get_busy(v.w)), 32'd0);
    endtask

    vec_t vecs [17];

    initial begin
        int   lat, done_cnt;
        logic seen, busy_ok;

        // width, mode, in1, in2, result, err, DONE-entry edge after capture
        vecs[0]  = '{8,  1'b0, 16'd12,    16'd8,   32'd4,          1'b0, 3};
        vecs[1]  = '{8,  1'b1, 16'd12,    16'd8,   32'd24,         1'b0, 19};
        vecs[2]  = '{8,  1'b1, 16'd255,   16'd254, 32'd64770,      1'b0, 271};
        vecs[3]  = '{8,  1'b0, 16'd0,     16'd9,   32'd9,          1'b0, 1};
        vecs[4]  = '{8,  1'b0, 16'd0,     16'd0,   32'd0,          1'b1, 1};
        vecs[5]  = '{8,  1'b1, 16'd0,     16'd5,   32'd0,          1'b0, 1};
        vecs[6]  = '{8,  1'b0, 16'd255,   16'd1,   32'd1,          1'b0, 255};
        vecs[7]  = '{8,  1'b0, 16'd17,    16'd13,  32'd1,          1'b0, 8};
        vecs[8]  = '{8,  1'b0, 16'd7,     16'd7,   32'd7,          1'b0, 1};
        vecs[9]  = '{8,  1'b1, 16'd7,     16'd7,   32'd7,          1'b0, 17};
        vecs[10] = '{8,  1'b1, 16'd0,     16'd0,   32'd0,          1'b1, 1};
        vecs[11] = '{4,  1'b0, 16'd15,    16'd10,  32'd5,          1'b0, 3};
        vecs[12] = '{4,  1'b1, 16'd15,    16'd10,  32'd30,         1'b0, 11};
        vecs[13] = '{4,  1'b1, 16'd15,    16'd14,  32'd210,        1'b0, 23};
        vecs[14] = '{4,  1'b0, 16'd0,     16'd0,   32'd0,          1'b1, 1};
        vecs[15] = '{16, 1'b0, 16'd65535, 16'd255, 32'd255,        1'b0, 257};
        vecs[16] = '{16, 1'b1, 16'd1000,  16'd600, 32'd3000,       1'b0, 36};

        reset = 1'b1;
        drive(4, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(16, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int w = 4; w <= 16; w = w * 2) begin
            check($sformatf("w%0d_reset_busy", w),   32'(get_busy(w)), 32'd0);
            check($sformatf("w%0d_reset_done", w),   32'(get_done(w)), 32'd0);
            check($sformatf("w%0d_reset_result", w), get_result(w),    32'd0);
            check($sformatf("w%0d_reset_err", w),    32'(get_err(w)),  32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Start pulsed while busy is ignored; operands stay captured.
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 16'd12, 16'd8);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b0, 16'd12, 16'd8);
        @(negedge clk);
        drive(8, 1'b1, 1'b1, 16'd3, 16'd3);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b1, 16'd3, 16'd3);
        wait_done(8, 1, lat, seen, busy_ok);
        check("ign_done_seen", 32'(seen), 32'd1);
        check("ign_latency", 32'(lat), 32'd3);
        check("ign_result", get_result(8), 32'd4);
        check("ign_err", 32'(get_err(8)), 32'd0);

        // Result holds in IDLE while inputs wander.
        drive(8, 1'b0, 1'b1, 16'd200, 16'd99);
        repeat (3) @(posedge clk);
        #1;
        check("hold_result", get_result(8), 32'd4);
        check("hold_idle", 32'(get_busy(8)), 32'd0);

        // Back-to-back with start held high.
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 16'd7, 16'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b2b_first_done", 32'(get_done(8)), 32'd1);
        @(posedge clk); #1;
        check("b2b_idle_gap", 32'(get_busy(8)), 32'd0);
        @(posedge clk); #1;
        check("b2b_relaunch", 32'(get_busy(8)), 32'd1);
        drive(8, 1'b0, 1'b0, 16'd7, 16'd7);
        @(posedge clk); #1;
        check("b2b_second_done", 32'(get_done(8)), 32'd1);
        check("b2b_result", get_result(8), 32'd7);
        @(posedge clk); #1;
        check("b2b_stop", 32'(get_busy(8)), 32'd0);

        // Reset in the middle of CALC aborts without a done pulse.
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 16'd255, 16'd1);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b0, 16'd255, 16'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(get_busy(8)), 32'd0);
        check("abort_done", 32'(get_done(8)), 32'd0);
        check("abort_result", get_result(8), 32'd0);
        check("abort_err", 32'(get_err(8)), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (get_done(8)) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // First operation after reset is accepted immediately.
        run_vec(100, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
